hex_chase: RTL and testbench

- Parametrised segment chaser for the board's 7-segment bank. A single lit segment walks across N_DIGITS digits, which is N_DIGITS*7 positions in total.
- Step rate comes from an internal tick divider. Supported modes are forward wrap, reverse wrap, bounce and hold.
- Sits directly behind the HEX display pins and replaces the fixed single-digit chaser driven by free-running counter bits.

---
 rtl/hex_chase.sv | 121 ++++++++++++
 tb/tb_hex_chase.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_chase.sv
// Segment chaser for a bank of 7-segment digits: one lit segment walks across
// N_DIGITS*7 positions, stepping on an internal tick, in wrap, bounce or hold modes.
module hex_chase #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 12500000
) (
  input  logic                              iCLK_50,
  input  logic                              iRST_N,
  input  logic                              iEN,
  input  logic [1:0]                        iMODE,
  input  logic                              iCLR,
  output logic [7*N_DIGITS-1:0]             oHEX_D,
  output logic [$clog2(N_DIGITS*7)-1:0]     oPOS,
  output logic                              oWRAP
);

  localparam int NPOS = N_DIGITS * 7;
  localparam int PW   = $clog2(NPOS);
  localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST    = PW'(NPOS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_FWD    = 2'd0,
    MODE_REV    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          dir_q, dir_d;   // 0 = up, 1 = down; remembered across mode changes
  logic          wrap_q, wrap_d;
  logic          tick;
  mode_e         mode;

  assign mode = mode_e'(iMODE);
  assign tick = iEN && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (iCLR) begin
      // Clear wins over everything, including a tick landing this cycle.
      cnt_d = '0;
      pos_d = '0;
      dir_d = 1'b0;
    end else if (iEN) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        case (mode)
          MODE_FWD: begin
            dir_d = 1'b0;
            if (pos_q == LAST) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end
          MODE_REV: begin
            dir_d = 1'b1;
            if (pos_q == '0) begin
              pos_d  = LAST;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (pos_q == LAST) begin
                pos_d  = LAST - PW'(1);
                dir_d  = 1'b1;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d  = PW'(1);
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  assign oPOS  = pos_q;
  assign oWRAP = wrap_q;

  // Segment bit index equals the position index, so each bit is a simple compare.
  generate
    for (genvar gi = 0; gi < NPOS; gi++) begin : g_seg
      assign oHEX_D[gi] = (pos_q != PW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_hex_chase.sv
// Scoreboard bench for hex_chase: two instances (2 digits / divide-by-4 and
// 1 digit / divide-by-1) share random stimulus and are checked against a reference model.
module tb_hex_chase;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        clr   = 1'b0;
  logic [1:0]  mode  = 2'd0;

  logic [13:0] hex_a;
  logic [3:0]  pos_a;
  logic        wrap_a;
  logic [6:0]  hex_b;
  logic [2:0]  pos_b;
  logic        wrap_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hex_chase #(.N_DIGITS(2), .TICK_DIV(4)) u_a (
    .iCLK_50(clk), .iRST_N(rst_n), .iEN(en), .iMODE(mode), .iCLR(clr),
    .oHEX_D(hex_a), .oPOS(pos_a), .oWRAP(wrap_a)
  );

  hex_chase #(.N_DIGITS(1), .TICK_DIV(1)) u_b (
    .iCLK_50(clk), .iRST_N(rst_n), .iEN(en), .iMODE(mode), .iCLR(clr),
    .oHEX_D(hex_b), .oPOS(pos_b), .oWRAP(wrap_b)
  );

  typedef struct {
    int cnt;
    int pos;
    bit dir;
    bit wrap;
  } st_t;

  st_t sa, sb;
  st_t qa[$];
  st_t qb[$];

  function automatic st_t rst_st();
    st_t s;
    s.cnt = 0; s.pos = 0; s.dir = 1'b0; s.wrap = 1'b0;
    return s;
  endfunction

  // Reference: one clock of the chaser, written from the behavioural rules.
  function automatic st_t mstep(st_t s, int last, int tdiv, bit e, bit c, int m);
    st_t n = s;
    n.wrap = 1'b0;
    if (c) return rst_st();
    if (!e) return n;
    if (s.cnt != tdiv - 1) begin
      n.cnt = s.cnt + 1;
      return n;
    end
    n.cnt = 0;
    if (m == 0) begin
      n.dir = 1'b0;
      n.wrap = (s.pos == last);
      n.pos = (s.pos + 1) % (last + 1);
    end else if (m == 1) begin
      n.dir = 1'b1;
      n.wrap = (s.pos == 0);
      n.pos = (s.pos + last) % (last + 1);
    end else if (m == 2) begin
      if (!s.dir && s.pos == last) begin
        n.pos = last - 1; n.dir = 1'b1; n.wrap = 1'b1;
      end else if (s.dir && s.pos == 0) begin
        n.pos = 1; n.dir = 1'b0; n.wrap = 1'b1;
      end else begin
        n.pos = s.dir ? s.pos - 1 : s.pos + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    sa = rst_st();
    sb = rst_st();
  end

  always @(negedge rst_n) begin
    sa = rst_st();
    sb = rst_st();
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      sa = rst_st();
      sb = rst_st();
    end else begin
      sa = mstep(sa, 13, 4, en, clr, int'(mode));
      sb = mstep(sb, 6, 1, en, clr, int'(mode));
    end
    qa.push_back(sa);
    qb.push_back(sb);
  end

  // Monitor: outputs are compared every cycle against the queued prediction.
  always @(negedge clk) begin
    st_t e;
    logic [55:0] h;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      h = '1;
      h[e.pos] = 1'b0;
      chk("a_pos", 64'(pos_a), 64'(e.pos));
      chk("a_wrap", 64'(wrap_a), 64'(e.wrap));
      chk("a_hex", 64'(hex_a), 64'(h[13:0]));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      h = '1;
      h[e.pos] = 1'b0;
      chk("b_pos", 64'(pos_b), 64'(e.pos));
      chk("b_wrap", 64'(wrap_b), 64'(e.wrap));
      chk("b_hex", 64'(hex_b), 64'(h[6:0]));
    end
  end

  task automatic clr_pulse(input logic [1:0] m);
    clr  = 1'b1;
    mode = m;
    @(negedge clk);
    clr  = 1'b0;
  endtask

  initial begin
    int nwrap;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 2'd0;
    $display("tb: reset released, forward mode");
    repeat (28) @(negedge clk);
    chk("pos7_hex", 64'(hex_a), 64'(14'b111_1110_111_1111));
    repeat (42) @(negedge clk);

    $display("tb: reverse mode");
    clr_pulse(2'd1);
    repeat (40) @(negedge clk);

    $display("tb: bounce mode from cleared state");
    clr_pulse(2'd2);
    nwrap = 0;
    for (int i = 1; i <= 112; i++) begin
      @(negedge clk);
      if (i == 1) chk("b_bounce_hex1", 64'(hex_b), 64'(7'b111_1101));
      if (i == 2) chk("b_bounce_hex2", 64'(hex_b), 64'(7'b111_1011));
      if (i >= 5 && wrap_a) nwrap++;
    end
    chk("a_bounce_wraps", 64'(nwrap), 64'd2);

    $display("tb: clear on tick at last position");
    clr_pulse(2'd0);
    repeat (55) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_tick_pos", 64'(pos_a), 64'd0);
    chk("clr_tick_wrap", 64'(wrap_a), 64'd0);
    repeat (3) @(negedge clk);
    chk("clr_next_pos_before", 64'(pos_a), 64'd0);
    @(negedge clk);
    chk("clr_next_pos_after", 64'(pos_a), 64'd1);

    $display("tb: enable drop mid-count");
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (12) @(negedge clk);

    $display("tb: hold mode");
    mode = 2'd3;
    repeat (80) @(negedge clk);

    $display("tb: random stimulus");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
      en  = ($urandom_range(7) != 0);
      clr = ($urandom_range(49) == 0);
      @(negedge clk);
    end
    clr = 1'b0;
    en  = 1'b1;
    mode = 2'd2;
    repeat (7) @(negedge clk);

    $display("tb: asynchronous reset between edges");
    #2 rst_n = 1'b0;
    #1;
    chk("async_pos_a", 64'(pos_a), 64'd0);
    chk("async_hex_a", 64'(hex_a), 64'(14'h3FFE));
    chk("async_wrap_a", 64'(wrap_a), 64'd0);
    chk("async_hex_b", 64'(hex_b), 64'(7'h7E));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) mode = 2'($urandom_range(3));
      en  = ($urandom_range(5) != 0);
      clr = ($urandom_range(79) == 0);
      @(negedge clk);
    end
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
